// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the asynchronous SRAM front end: FSM encodings and
// the cycle counts of each access type at the 10 ns system clock.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_TURN     = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } sram_state_t;

    localparam int READ_LATENCY = 2;
    localparam int WRITE_CYCLES = 3;
    localparam int TURN_CYCLES  = 1;

endpackage

// File: rtl/sram_io_pad.sv
// Tristate data pad for the SRAM data bus. Behavioural in simulation;
// mapped onto SB_IO primitives for iCE40 builds.
module sram_io_pad #(
    parameter int WIDTH = 8
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] pad
);

`ifdef ICE40
    for (genvar i = 0; i < WIDTH; i++) begin : g_io
        SB_IO #(
            .PIN_TYPE(6'b1010_01)
        ) u_io (
            .PACKAGE_PIN  (pad[i]),
            .OUTPUT_ENABLE(oe),
            .D_OUT_0      (dout[i]),
            .D_IN_0       (din[i])
        );
    end
`else
    assign pad = oe ? dout : {WIDTH{1'bz}};
    assign din = pad;
`endif

endmodule

// File: rtl/sram_controller.sv
// Synchronous valid/ready front end for an asynchronous SRAM; all SRAM pins
// are registered and the read data is returned with a one-cycle strobe.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | chip deselected, bus released, accepting requests
// ST_READ      | ce_n/oe_n low, address on pins, word sampled next edge
// ST_TURN      | one dead cycle after a read so oe_n rises before any drive
// ST_WR_SETUP  | address and data driven, we_n still high
// ST_WR_PULSE  | we_n low for one cycle
// ST_WR_HOLD   | we_n high again, address and data still held
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic [ADDR_BITS-1:0] sram_addr,
    inout  wire  [DATA_BITS-1:0] sram_data_io,
    output logic                 sram_we_n,
    output logic                 sram_oe_n,
    output logic                 sram_ce_n
);

    sram_state_t          state, state_nxt;
    logic                 accept;
    logic [ADDR_BITS-1:0] addr_nxt;
    logic [DATA_BITS-1:0] wdata_q, wdata_nxt;
    logic [DATA_BITS-1:0] din;
    logic                 drive, drive_nxt;
    logic                 ce_n_nxt, oe_n_nxt, we_n_nxt;

    assign req_ready = (state == ST_IDLE) || (state == ST_READ);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = sram_addr;
        wdata_nxt = wdata_q;
        ce_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        drive_nxt = 1'b0;
        case (state)
            ST_IDLE, ST_READ: begin
                if (accept) begin
                    addr_nxt = req_addr;
                    if (req_write) begin
                        // Leaving READ, oe_n must rise a full cycle before the bus is driven
                        wdata_nxt = req_wdata;
                        state_nxt = (state == ST_READ) ? ST_TURN : ST_WR_SETUP;
                        ce_n_nxt  = (state == ST_READ);
                        drive_nxt = (state == ST_IDLE);
                    end else begin
                        state_nxt = ST_READ;
                        ce_n_nxt  = 1'b0;
                        oe_n_nxt  = 1'b0;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TURN: begin
                state_nxt = ST_WR_SETUP;
                ce_n_nxt  = 1'b0;
                drive_nxt = 1'b1;
            end
            ST_WR_SETUP: begin
                state_nxt = ST_WR_PULSE;
                ce_n_nxt  = 1'b0;
                we_n_nxt  = 1'b0;
                drive_nxt = 1'b1;
            end
            ST_WR_PULSE: begin
                state_nxt = ST_WR_HOLD;
                ce_n_nxt  = 1'b0;
                drive_nxt = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            drive     <= 1'b0;
            wdata_q   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            sram_addr <= addr_nxt;
            sram_ce_n <= ce_n_nxt;
            sram_oe_n <= oe_n_nxt;
            sram_we_n <= we_n_nxt;
            drive     <= drive_nxt;
            wdata_q   <= wdata_nxt;
            rd_valid  <= (state == ST_READ);
            if (state == ST_READ) rd_data <= din;
        end
    end

    sram_io_pad #(
        .WIDTH(DATA_BITS)
    ) u_pad (
        .oe  (drive),
        .dout(wdata_q),
        .din (din),
        .pad (sram_data_io)
    );

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Synchronous front end for the external asynchronous SRAM; sits directly upstream of the SRAM part, and of the SRAM simulation model in benches.
- Accepts single-word read/write requests on a valid/ready handshake.
- Generates the ce_n/oe_n/we_n/address/data waveforms at 100 MHz (10 ns period) and returns registered read data with a one-cycle valid strobe.

Parameters:
- ADDR_BITS, 10, SRAM address width.
- DATA_BITS, 8, SRAM data width.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read; qualified by req_valid.
- req_addr  input  ADDR_BITS  request address.
- req_wdata  input  DATA_BITS  write data.
- rd_data  output  DATA_BITS  registered read data.
- rd_valid  output  1  single-cycle pulse; rd_data is valid this cycle.
- sram_addr  output  ADDR_BITS  SRAM address pins.
- sram_data_io  inout  DATA_BITS  SRAM data pins.
- sram_we_n  output  1  write enable, active low.
- sram_oe_n  output  1  output enable, active low.
- sram_ce_n  output  1  chip enable, active low.

Behaviour:
- All SRAM pin outputs are registered; no combinational path from req_* to sram_*.
- Accept = req_valid && req_ready at a rising edge.
- Reset values:
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_addr=0.
  - Data bus not driven (Z).
  - rd_data=0, rd_valid=0.
  - State IDLE.
- States: IDLE, READ, TURN, WR_SETUP, WR_PULSE, WR_HOLD. Encodings are in the package.
- req_ready=1 in IDLE and READ; 0 in all other states. req_ready depends on state only, never on req_write.
- Read accepted at edge N:
  - Edge N+1: sram_addr=req_addr, ce_n=0, oe_n=0; state READ.
  - Edge N+2: rd_data samples sram_data_io; rd_valid=1 for one cycle. Read latency is 2 cycles.
  - Address is stable for one full 10 ns period before the sample (meets 9 ns tAA and 6 ns tDOE).
- Back-to-back reads:
  - A read accepted while in READ updates sram_addr at the same edge that samples the previous word.
  - Throughput is 1 word/cycle.
  - oe_n stays low throughout.
- Write accepted in IDLE:
  - WR_SETUP: sram_addr and data latched, bus driven, we_n=1, oe_n=1, ce_n=0.
  - WR_PULSE: we_n=0 for exactly one cycle (10 ns ≥ 8 ns tAW).
  - WR_HOLD: we_n=1; address and data still held and driven.
  - Next edge: bus released, state IDLE.
  - Address and data must not change while we_n=0 or on its rising edge.
- Write accepted in READ:
  - Previous read still completes (rd_valid next cycle).
  - State goes to TURN: oe_n=1, bus not driven, one cycle.
  - Then WR_SETUP. This avoids driver contention.
- Bus drive:
  - Driven only in WR_SETUP/WR_PULSE/WR_HOLD.
  - Never driven in any cycle where oe_n=0.
- IDLE with no request: ce_n=1, oe_n=1; sram_addr holds its last value.
- Request in READ with req_valid=0: next state IDLE (ce_n=1, oe_n=1) once the sample is taken.
- Reset mid-operation:
  - All outputs take their reset values at the next edge, including an abrupt we_n release.
  - Contents of an interrupted write are undefined.
  - No rd_valid is issued for an interrupted read.
- rd_valid is never asserted for writes.

Decomposition:
- Package sram_ctrl_pkg:
  - State encoding localparams.
  - Timing constants in cycles: READ_LATENCY=2, WRITE_CYCLES=3, TURN_CYCLES=1.
- Sub-module sram_io_pad: tristate data pad.
  - Inputs: oe, dout. Output: din. Inout: pad.
  - Behavioural assign in simulation; SB_IO on iCE40.
- Controller FSM stays in sram_controller.

Test Plan:
- Reset: assert reset 3 cycles → ce_n=oe_n=we_n=1, bus Z, rd_valid=0, req_ready=1.
- Single write/read: write addr 0x055 data 0xA5, then read 0x055 → rd_valid exactly 2 cycles after read accept, rd_data=0xA5. Bench uses the SRAM model (ADDR_BITS 10, DATA_BITS 8); its addr/data-stability checks must not fire.
- Streaming reads: write 0x00..0x0F with data=addr^0x3C, then 16 back-to-back reads with req_valid held high → 16 consecutive rd_valid pulses, data 0x3C..0x33 in order, oe_n low continuously.
- Read then write: read 0x010 immediately followed by write 0x010=0x77 → rd_valid for the read; one TURN cycle with oe_n=1 and bus Z before any drive; we_n low exactly 1 cycle; readback 0x77.
- Write timing: write 0x3FF=0xFF → req_ready low 3 cycles; we_n low 1 cycle; sram_addr/data unchanged from WR_SETUP through WR_HOLD.
- Reset mid-write: assert reset during WR_PULSE → next edge we_n=1, bus Z, state IDLE; subsequent write/read of 0x001=0x5A returns 0x5A.
